regbus_master: RTL

Bus initiator for the team's custom register bus (addr / chip_select / write_en / read_en / write_data / read_data / data_valid). It converts single upstream commands (valid/ready) into bus write strobes or read transactions and returns one response per command. A read times out if data_valid never arrives. It sits between a CPU/bridge command port and any generated register-file slave.

---
 rtl/regbus_master.sv | 117 +++++++++++
 1 files changed

// File: rtl/regbus_master.sv
// regbus_master: turns single valid/ready commands into register-bus
// write strobes or read transactions, one response per command.
module regbus_master #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 15
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_error,
    output logic                  busy,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  chip_select,
    output logic                  write_en,
    output logic                  read_en,
    output logic [DATA_WIDTH-1:0] write_data,
    input  logic [DATA_WIDTH-1:0] read_data,
    input  logic                  data_valid
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE,
        WR,
        RD,
        RSP
    } state_t;

    state_t        state;
    logic [CW-1:0] rd_cnt;
    logic          dv_ok;
    logic          rd_to;

    // a pulse in RD cycle 0 belongs to an earlier read
    assign dv_ok = data_valid && (rd_cnt != '0);
    assign rd_to = (rd_cnt == CW'(TIMEOUT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            rd_cnt      <= '0;
            cmd_ready   <= 1'b1;
            busy        <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_error   <= 1'b0;
            addr        <= '0;
            write_data  <= '0;
            chip_select <= 1'b0;
            write_en    <= 1'b0;
            read_en     <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        addr        <= cmd_addr;
                        write_data  <= cmd_wdata;
                        rd_cnt      <= '0;
                        cmd_ready   <= 1'b0;
                        busy        <= 1'b1;
                        chip_select <= 1'b1;
                        write_en    <= cmd_write;
                        read_en     <= !cmd_write;
                        state       <= cmd_write ? WR : RD;
                    end
                end
                WR: begin
                    chip_select <= 1'b0;
                    write_en    <= 1'b0;
                    rsp_rdata   <= '0;
                    rsp_error   <= 1'b0;
                    rsp_valid   <= 1'b1;
                    state       <= RSP;
                end
                RD: begin
                    if (dv_ok || rd_to) begin
                        chip_select <= 1'b0;
                        read_en     <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_rdata   <= dv_ok ? read_data : '0;
                        rsp_error   <= !dv_ok;
                        state       <= RSP;
                    end else begin
                        rd_cnt <= rd_cnt + CW'(1);
                    end
                end
                RSP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state       <= IDLE;
                    cmd_ready   <= 1'b1;
                    busy        <= 1'b0;
                    rsp_valid   <= 1'b0;
                    chip_select <= 1'b0;
                    write_en    <= 1'b0;
                    read_en     <= 1'b0;
                end
            endcase
        end
    end

endmodule
